// File: rtl/banco_registradores_param.sv
// Datapath register bank: MAR/MDR/H plus NREGS general registers, a B-bus
// source mux, C-bus write enables and a small memory-command FSM with
// request/ack handshake, wait-cycle timeout and a sticky error flag.

// One datapath register with synchronous active-low clear and write enable.
module banco_reg_cel #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // Register: reset wins over the C-bus enable.
  always_ff @(posedge clock) begin
    if (!reset_n)  q <= '0;
    else if (we)   q <= d;
  end
endmodule

module banco_registradores_param #(
  parameter int WIDTH   = 32,
  parameter int NREGS   = 8,
  parameter int SEL_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [SEL_W-1:0]   bbus_sel,
  input  logic [NREGS+2:0]   cbus_en,
  input  logic [WIDTH-1:0]   cbus_in,
  input  logic               mem_rd,
  input  logic               mem_wr,
  input  logic [WIDTH-1:0]   mem_rdata,
  input  logic               mem_ack,
  output logic [WIDTH-1:0]   bbus_out,
  output logic [WIDTH-1:0]   h_out,
  output logic               mem_req,
  output logic               mem_we,
  output logic [WIDTH-1:0]   mem_addr,
  output logic [WIDTH-1:0]   mem_wdata,
  output logic               busy,
  output logic               cmd_err
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} mem_state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [WIDTH-1:0]             mar, mdr, h;
  logic [NREGS-1:0][WIDTH-1:0]  gr;

  mem_state_t       state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [WIDTH-1:0] addr_d, wdata_d;
  logic             we_d, err_d, mdr_load;

  // MAR and H are plain C-bus registers.
  banco_reg_cel #(.WIDTH(WIDTH)) u_mar (
    .clock(clock), .reset_n(reset_n), .we(cbus_en[0]), .d(cbus_in), .q(mar));
  banco_reg_cel #(.WIDTH(WIDTH)) u_h (
    .clock(clock), .reset_n(reset_n), .we(cbus_en[2]), .d(cbus_in), .q(h));

  // General registers, one cell per GR[i] on enable bit 3+i.
  for (genvar g = 0; g < NREGS; g++) begin : g_gr
    banco_reg_cel #(.WIDTH(WIDTH)) u_gr (
      .clock(clock), .reset_n(reset_n), .we(cbus_en[3+g]), .d(cbus_in), .q(gr[g]));
  end

  // MDR: a completing read beats a same-cycle C-bus write.
  always_ff @(posedge clock) begin
    if (!reset_n)          mdr <= '0;
    else if (mdr_load)     mdr <= mem_rdata;
    else if (cbus_en[1])   mdr <= cbus_in;
  end

  // B-bus source mux; out-of-range selects read as zero.
  always_comb begin
    bbus_out = '0;
    if (bbus_sel == '0) bbus_out = mdr;
    for (int i = 0; i < NREGS; i++)
      if (bbus_sel == SEL_W'(i + 1)) bbus_out = gr[i];
  end

  assign h_out   = h;
  assign busy    = (state_q != IDLE);
  assign mem_req = busy;

  // Memory FSM next state: issue from IDLE using pre-edge MAR/MDR, then wait
  // for ack or give up after TIMEOUT wait cycles.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    addr_d   = mem_addr;
    wdata_d  = mem_wdata;
    we_d     = mem_we;
    err_d    = cmd_err;
    mdr_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_wr) begin
          addr_d  = mar;
          wdata_d = mdr;
          we_d    = 1'b1;
          wait_d  = '0;
          state_d = WR_WAIT;
          if (mem_rd) err_d = 1'b1;   // conflicting read is dropped
        end else if (mem_rd) begin
          addr_d  = mar;
          we_d    = 1'b0;
          wait_d  = '0;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (mem_rd || mem_wr) err_d = 1'b1;  // command while busy is ignored
        if (mem_ack) begin
          mdr_load = (state_q == RD_WAIT);
          wait_d   = '0;
          state_d  = IDLE;
        end else if (wait_q == TO_LAST) begin
          err_d   = 1'b1;
          wait_d  = '0;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory FSM state and latched command outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      mem_we    <= we_d;
      cmd_err   <= err_d;
    end
  end
endmodule

// File: tb/tb_banco_registradores_param.sv
// Directed bench for banco_registradores_param with default parameters.
module tb_banco_registradores_param;
  localparam int WIDTH = 32, NREGS = 8, SEL_W = 4, TIMEOUT = 15;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [SEL_W-1:0]  bbus_sel;
  logic [NREGS+2:0]  cbus_en;
  logic [WIDTH-1:0]  cbus_in;
  logic              mem_rd, mem_wr, mem_ack;
  logic [WIDTH-1:0]  mem_rdata;
  logic [WIDTH-1:0]  bbus_out, h_out, mem_addr, mem_wdata;
  logic              mem_req, mem_we, busy, cmd_err;

  int n_cmp = 0;
  int n_bad = 0;

  banco_registradores_param #(.WIDTH(WIDTH), .NREGS(NREGS), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n), .bbus_sel(bbus_sel), .cbus_en(cbus_en),
    .cbus_in(cbus_in), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .bbus_out(bbus_out), .h_out(h_out), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .cmd_err(cmd_err));

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bbus_sel = '0; cbus_en = '0; cbus_in = '0;
    mem_rd = 0; mem_wr = 0; mem_ack = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic cbus_write(input logic [NREGS+2:0] en, input logic [WIDTH-1:0] d);
    cbus_en = en; cbus_in = d;
    tick();
    cbus_en = '0; cbus_in = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    n_cmp++; if ({mem_req, busy, cmd_err, mem_we} !== 4'b0) begin n_bad++;
      $display("FAIL reset_flags got=%b exp=0000", {mem_req, busy, cmd_err, mem_we}); end
    n_cmp++; if (mem_addr !== 0 || mem_wdata !== 0) begin n_bad++;
      $display("FAIL reset_mem_bus got addr=%h wdata=%h exp 0", mem_addr, mem_wdata); end
    n_cmp++; if (h_out !== 0 || bbus_out !== 0) begin n_bad++;
      $display("FAIL reset_regs got h=%h b=%h exp 0", h_out, bbus_out); end
    reset_n = 1'b1;
  endtask

  task automatic test_bbus();
    do_reset();
    cbus_write(11'h020, 32'hDEADBEEF);             // GR[2]
    cbus_write(11'h006, 32'h00C0FFEE);             // MDR and H together
    bbus_sel = 4'd3; #1;
    n_cmp++; if (bbus_out !== 32'hDEADBEEF) begin n_bad++;
      $display("FAIL bbus_gr2 got=%h exp=deadbeef", bbus_out); end
    bbus_sel = 4'd15; #1;
    n_cmp++; if (bbus_out !== 32'h0) begin n_bad++;
      $display("FAIL bbus_sel15 got=%h exp=0", bbus_out); end
    bbus_sel = 4'd9; #1;
    n_cmp++; if (bbus_out !== 32'h0) begin n_bad++;
      $display("FAIL bbus_sel9 got=%h exp=0", bbus_out); end
    bbus_sel = 4'd0; #1;
    n_cmp++; if (bbus_out !== 32'h00C0FFEE || h_out !== 32'h00C0FFEE) begin n_bad++;
      $display("FAIL multi_enable got mdr=%h h=%h exp 00c0ffee", bbus_out, h_out); end
    cbus_write(11'h400, 32'h11112222);             // GR[7]
    bbus_sel = 4'd8; #1;
    n_cmp++; if (bbus_out !== 32'h11112222) begin n_bad++;
      $display("FAIL bbus_gr7 got=%h exp=11112222", bbus_out); end
    bbus_sel = 4'd3; #1;
    n_cmp++; if (bbus_out !== 32'hDEADBEEF) begin n_bad++;
      $display("FAIL gr2_kept got=%h exp=deadbeef", bbus_out); end
  endtask

  task automatic test_read();
    do_reset();
    cbus_write(11'h001, 32'h10);                   // MAR
    mem_rd = 1; tick(); mem_rd = 0;
    for (int c = 1; c <= 3; c++) begin
      n_cmp++; if (mem_req !== 1 || mem_addr !== 32'h10 || mem_we !== 0 || busy !== 1) begin n_bad++;
        $display("FAIL read_wait c=%0d got req=%b addr=%h we=%b busy=%b exp 1 10 0 1", c, mem_req, mem_addr, mem_we, busy); end
      if (c < 3) tick();
    end
    mem_ack = 1; mem_rdata = 32'h1234;
    cbus_en = 11'h002; cbus_in = 32'hFFFF;          // loses to memory data
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (bbus_out !== 32'h1234) begin n_bad++;
      $display("FAIL read_mdr got=%h exp=1234", bbus_out); end
    n_cmp++; if (mem_req !== 0 || busy !== 0 || cmd_err !== 0 || mem_addr !== 32'h10) begin n_bad++;
      $display("FAIL read_done got req=%b busy=%b err=%b addr=%h exp 0 0 0 10", mem_req, busy, cmd_err, mem_addr); end
  endtask

  task automatic test_rd_wr_conflict();
    do_reset();
    cbus_write(11'h002, 32'hA5);                   // MDR
    cbus_write(11'h001, 32'h4);                    // MAR
    mem_wr = 1; mem_rd = 1;
    cbus_en = 11'h001; cbus_in = 32'h99;           // same-edge MAR write
    tick();
    idle_inputs();
    n_cmp++; if (mem_req !== 1 || mem_we !== 1 || mem_wdata !== 32'hA5 || mem_addr !== 32'h4 || cmd_err !== 1) begin n_bad++;
      $display("FAIL conflict got req=%b we=%b wdata=%h addr=%h err=%b exp 1 1 a5 4 1", mem_req, mem_we, mem_wdata, mem_addr, cmd_err); end
    mem_ack = 1; mem_rdata = 32'h5555; tick(); mem_ack = 0;
    n_cmp++; if (busy !== 0 || bbus_out !== 32'hA5 || mem_wdata !== 32'hA5) begin n_bad++;
      $display("FAIL write_done got busy=%b mdr=%h wdata=%h exp 0 a5 a5", busy, bbus_out, mem_wdata); end
    tick();
    n_cmp++; if (busy !== 0) begin n_bad++;
      $display("FAIL dropped_read got busy=%b exp=0", busy); end
    mem_rd = 1; tick(); mem_rd = 0;
    n_cmp++; if (busy !== 1 || mem_we !== 0 || mem_addr !== 32'h99) begin n_bad++;
      $display("FAIL next_read got busy=%b we=%b addr=%h exp 1 0 99", busy, mem_we, mem_addr); end
  endtask

  task automatic test_timeout();
    int cnt;
    do_reset();
    cbus_write(11'h002, 32'h77);
    mem_rd = 1; tick(); mem_rd = 0;
    cnt = 0;
    while (mem_req === 1 && cnt < 40) begin cnt++; tick(); end
    n_cmp++; if (cnt !== TIMEOUT) begin n_bad++;
      $display("FAIL timeout_len got=%0d exp=%0d", cnt, TIMEOUT); end
    n_cmp++; if (bbus_out !== 32'h77 || cmd_err !== 1 || busy !== 0) begin n_bad++;
      $display("FAIL timeout_state got mdr=%h err=%b busy=%b exp 77 1 0", bbus_out, cmd_err, busy); end
  endtask

  task automatic test_busy_cmd();
    do_reset();
    cbus_write(11'h001, 32'h20);
    mem_rd = 1; tick(); mem_rd = 0;
    mem_wr = 1; tick(); mem_wr = 0;
    n_cmp++; if (cmd_err !== 1 || mem_we !== 0 || busy !== 1) begin n_bad++;
      $display("FAIL cmd_while_busy got err=%b we=%b busy=%b exp 1 0 1", cmd_err, mem_we, busy); end
    mem_ack = 1; mem_rdata = 32'hCAFE; tick();
    mem_ack = 1; mem_rdata = 32'hBAD;  tick();     // ack in IDLE
    mem_ack = 0;
    n_cmp++; if (bbus_out !== 32'hCAFE || busy !== 0 || cmd_err !== 1) begin n_bad++;
      $display("FAIL ack_idle got mdr=%h busy=%b err=%b exp cafe 0 1", bbus_out, busy, cmd_err); end
  endtask

  task automatic test_reset_abort();
    do_reset();
    cbus_write('1, 32'h5A5A5A5A);                  // every register
    mem_wr = 1; mem_rd = 1; tick();                // sets cmd_err, write in flight
    idle_inputs();
    reset_n = 0; cbus_en = '1; cbus_in = 32'hFFFFFFFF; mem_ack = 1; mem_rdata = 32'h42;
    tick();
    reset_n = 1; cbus_en = '0;
    n_cmp++; if ({mem_req, busy, cmd_err, mem_we} !== 4'b0 || mem_addr !== 0 || mem_wdata !== 0 || h_out !== 0) begin n_bad++;
      $display("FAIL abort got req=%b busy=%b err=%b we=%b addr=%h wd=%h h=%h exp zeros", mem_req, busy, cmd_err, mem_we, mem_addr, mem_wdata, h_out); end
    for (int s = 0; s <= NREGS; s++) begin
      bbus_sel = SEL_W'(s); #1;
      n_cmp++; if (bbus_out !== 0) begin n_bad++;
        $display("FAIL abort_reg sel=%0d got=%h exp=0", s, bbus_out); end
    end
    bbus_sel = 0;
    tick();                                        // late ack still high
    mem_ack = 0;
    n_cmp++; if (bbus_out !== 0 || busy !== 0) begin n_bad++;
      $display("FAIL late_ack got mdr=%h busy=%b exp 0 0", bbus_out, busy); end
  endtask

  initial begin
    test_reset();
    test_bbus();
    test_read();
    test_rd_wr_conflict();
    test_timeout();
    test_busy_cmd();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/banco_registradores_param.md
BANCO_REGISTRADORES_PARAM -- requirements
Module: banco_registradores_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width of every register and bus.
REQ-002 SHALL have parameter NREGS, default 8, number of general registers GR[0..NREGS-1] (SP, LV, CPP, TOS, OPC and spares).
REQ-003 SHALL have parameter SEL_W, default 4, width of the B-bus select (2^SEL_W >= NREGS+1).
REQ-004 SHALL have parameter TIMEOUT, default 15, maximum wait cycles for mem_ack (1..255).
REQ-005 SHALL have ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- bbus_sel  in  SEL_W  B-bus source select.
- cbus_en  in  NREGS+3  C-bus write enables: bit0 MAR, bit1 MDR, bit2 H, bit(3+i) GR[i].
- cbus_in  in  WIDTH  C-bus write data.
- mem_rd  in  1  read command pulse.
- mem_wr  in  1  write command pulse.
- mem_rdata  in  WIDTH  memory read data.
- mem_ack  in  1  memory completion.
- bbus_out  out  WIDTH  B-bus to ALU.
- h_out  out  WIDTH  H register to ALU.
- mem_req  out  1  memory request, held until ack or timeout.
- mem_we  out  1  1 = write, 0 = read, valid while mem_req.
- mem_addr  out  WIDTH  address latched at issue.
- mem_wdata  out  WIDTH  write data latched at issue.
- busy  out  1  memory transaction in flight.
- cmd_err  out  1  sticky error flag.

Function
REQ-006 SHALL decode bbus_sel combinationally: 0 -> MDR, 1..NREGS -> GR[sel-1], any other value -> all zeros (never Z or X).
REQ-007 SHALL drive h_out continuously from H.
REQ-008 SHALL write each register whose cbus_en bit is 1 from cbus_in at the rising edge; multiple simultaneous enables are all honoured.
REQ-009 SHALL implement memory FSM states IDLE, RD_WAIT, WR_WAIT; busy = (state != IDLE).
REQ-010 In IDLE with mem_wr=1: latch mem_addr<=MAR, mem_wdata<=MDR, mem_req<=1, mem_we<=1, go to WR_WAIT on the next edge.
REQ-011 In IDLE with mem_rd=1 and mem_wr=0: latch mem_addr<=MAR, mem_req<=1, mem_we<=0, go to RD_WAIT.
REQ-012 If mem_rd and mem_wr are both 1 in IDLE, SHALL perform the write only, drop the read, and set cmd_err.
REQ-013 The operand is the MAR/MDR value before the edge; a same-cycle C-bus write to MAR/MDR affects only later transactions.
REQ-014 In RD_WAIT with mem_ack=1: MDR<=mem_rdata, mem_req<=0, go to IDLE; memory data overrides a same-cycle cbus_en[1] write.
REQ-015 In WR_WAIT with mem_ack=1: mem_req<=0, go to IDLE; MDR unchanged.
REQ-016 mem_ack in IDLE SHALL be ignored.
REQ-017 mem_rd or mem_wr while busy SHALL be ignored and SHALL set cmd_err.
REQ-018 SHALL count wait cycles from 0 on entering a WAIT state; if the count reaches TIMEOUT with no ack: mem_req<=0, go to IDLE, MDR unchanged, set cmd_err.
REQ-019 A new command SHALL be accepted on the cycle after busy falls (one idle cycle minimum between transactions).
REQ-020 mem_addr and mem_wdata SHALL hold their last latched value while in IDLE.
REQ-021 cmd_err SHALL clear only on reset.

Reset
REQ-022 With reset_n=0 at a rising edge: all registers, mem_addr and mem_wdata SHALL be 0; mem_req, mem_we, busy and cmd_err SHALL be 0; state SHALL be IDLE; wait count SHALL be 0.
REQ-023 Reset SHALL take priority over C-bus writes, commands and mem_ack, and SHALL abort an in-flight transaction with mem_req=0 from the next cycle.

Verification
REQ-024 Write GR[2]=0xDEADBEEF via cbus_en bit5, then bbus_sel=3 -> bbus_out=0xDEADBEEF; bbus_sel=15 -> bbus_out=0.
REQ-025 MAR=0x10, pulse mem_rd, ack 3 cycles later with mem_rdata=0x1234 -> mem_req=1, mem_addr=0x10 for 3 cycles; MDR=0x1234 after ack; busy=0 next cycle.
REQ-026 MDR=0xA5, MAR=0x4, pulse mem_wr and mem_rd together -> mem_we=1, mem_wdata=0xA5, cmd_err=1, no read occurs.
REQ-027 Pulse mem_rd, never ack -> mem_req drops after TIMEOUT=15 wait cycles; MDR unchanged; cmd_err=1.
REQ-028 Pulse mem_rd with ack pending; assert reset_n=0 for 1 cycle -> mem_req=0, busy=0, all registers 0, cmd_err=0; a later ack is ignored.
